// File: rtl/spi_tx_sched_pkg.sv
// spi_tx_sched_pkg: FSM states, status bit positions, control bits and default addresses
package spi_tx_sched_pkg;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;
    localparam logic [31:0] TX_ADDR_DEF   = 32'h0000_00F8;
    localparam logic [31:0] CTRL_ADDR_DEF = 32'h0000_00FC;
    localparam int ST_ACTIVE    = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_FULL      = 2;
    localparam int ST_ERR       = 3;
    localparam int ST_CNT       = 4;
    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_ERR = 1;
endpackage

// File: rtl/spi_tx_sched_fifo.sv
// spi_tx_sched_fifo: sync FIFO with flush and registered (non-fall-through) read on pop
module spi_tx_sched_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic                      i_flush,
    input  logic [DATA_W-1:0]         i_data,
    output logic [DATA_W-1:0]         o_data,
    output logic [$clog2(DEPTH):0]    o_cnt,
    output logic                      o_full,
    output logic                      o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr, r_rd;
    logic [CW-1:0]     r_cnt;
    logic              w_push, w_pop;
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_cnt   = r_cnt;
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;
    always_ff @(posedge i_clk)
        if (w_push) r_mem[r_wr] <= i_data;
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + AW'(w_push);
            r_rd  <= r_rd + AW'(w_pop);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
    // o_data keeps the last popped word; a flush does not clear it
    always_ff @(posedge i_clk) begin
        if (i_reset)    o_data <= '0;
        else if (w_pop) o_data <= r_mem[r_rd];
    end
endmodule

// File: rtl/spi_tx_sched.sv
// spi_tx_sched: queues stores to the SPI TX address and launches them one at a time into SPI_Ctrl
module spi_tx_sched
    import spi_tx_sched_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] TX_ADDR   = TX_ADDR_DEF,
    parameter logic [31:0] CTRL_ADDR = CTRL_ADDR_DEF,
    parameter int          BUSY_TMO  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_we,
    output logic              o_stall,
    output logic [DATA_W-1:0] o_spi_data,
    output logic              o_spi_start,
    input  logic              i_spi_busy,
    output logic [31:0]       o_status
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(BUSY_TMO + 1);
    state_t        r_state;
    logic          r_start, r_err;
    logic [TW-1:0] r_tmo;
    logic          w_tx, w_ctrl, w_flush, w_clr_err, w_launch, w_full, w_empty;
    logic [CW-1:0] w_cnt;
    assign w_tx        = i_we && i_addr == TX_ADDR;
    assign w_ctrl      = i_we && i_addr == CTRL_ADDR;
    assign w_flush     = w_ctrl && i_data[CTRL_FLUSH];
    assign w_clr_err   = w_ctrl && i_data[CTRL_CLR_ERR];
    assign o_stall     = w_tx && w_full;
    assign o_spi_start = r_start;
    // the pop happens on the edge entering LAUNCH so the word and the strobe appear together
    assign w_launch    = r_state == S_IDLE && !w_empty && !i_spi_busy && !w_flush;
    spi_tx_sched_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_tx),
        .i_pop   (w_launch),
        .i_flush (w_flush),
        .i_data  (i_data),
        .o_data  (o_spi_data),
        .o_cnt   (w_cnt),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_err   <= 1'b0;
            r_tmo   <= '0;
        end else begin
            r_start <= w_launch;
            if (w_clr_err) r_err <= 1'b0;
            case (r_state)
                S_IDLE:    if (w_launch) r_state <= S_LAUNCH;
                S_LAUNCH: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (i_spi_busy) r_state <= S_WAIT_LO;
                    else if (r_tmo == TW'(BUSY_TMO - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else r_tmo <= r_tmo + 1'b1;
                end
                S_WAIT_LO: if (!i_spi_busy) r_state <= S_IDLE;
            endcase
        end
    end
    always_comb begin
        o_status                = '0;
        o_status[ST_ACTIVE]     = r_state != S_IDLE;
        o_status[ST_EMPTY]      = w_empty;
        o_status[ST_FULL]       = w_full;
        o_status[ST_ERR]        = r_err;
        o_status[ST_CNT +: 4]   = 4'(w_cnt);
    end
endmodule

// File: tb/tb_spi_tx_sched.sv
// tb_spi_tx_sched: vector table, directed corner sequences and random traffic against a queue model
module tb_spi_tx_sched;
    localparam int DEPTH = 4;
    localparam logic [31:0] TX   = 32'h0000_00F8;
    localparam logic [31:0] CTRL = 32'h0000_00FC;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_stall;
        int          exp_cnt;
    } vec_t;
    logic clk = 0, rst = 1, we = 0, busy = 0;
    logic [31:0] addr = 0, data = 0, spi_data, status;
    logic stall, start;
    int total = 0, bad = 0, starts = 0, hi_wait = -1, hi_left = 0, busy_dly = 1, busy_len = 3;
    bit bm_en = 0;
    logic [31:0] q[$];
    vec_t tbl[14];
    always #5 clk = ~clk;
    spi_tx_sched #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_data(data), .i_we(we),
        .o_stall(stall), .o_spi_data(spi_data), .o_spi_start(start),
        .i_spi_busy(busy), .o_status(status)
    );
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    // one clock: check stall, advance the queue model, check the launched word and count, drive the busy model
    task automatic step();
        bit tx, push_ok, flush;
        #1;
        tx      = we && addr == TX;
        push_ok = tx && q.size() < DEPTH;
        flush   = we && addr == CTRL && data[0];
        chk("stall", stall, 32'(tx && q.size() == DEPTH));
        @(posedge clk);
        #1;
        if (flush) q.delete();
        else if (push_ok) q.push_back(data);
        if (start) begin
            starts++;
            chk("start_while_busy", busy, 0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL start_empty: launch with no queued word, data %h", spi_data);
            end else begin
                chk("launch_data", spi_data, q[0]);
                void'(q.pop_front());
            end
        end
        chk("cnt", status[7:4], 32'(q.size()));
        if (bm_en) begin
            if (start) hi_wait = busy_dly;
            if (hi_wait == 0) begin
                busy = 1;
                hi_left = busy_len;
                hi_wait = -1;
            end else if (hi_wait > 0) hi_wait--;
            else if (busy) begin
                hi_left--;
                if (hi_left == 0) busy = 0;
            end
        end
    endtask
    task automatic do_reset();
        we = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        q.delete();
        busy = 0;
        hi_wait = -1;
        hi_left = 0;
        starts = 0;
    endtask
    task automatic push_word(logic [31:0] w);
        bit acc = 0;
        we = 1;
        addr = TX;
        data = w;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = q.size() < DEPTH;
            step();
        end
        we = 0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL push_timeout: word %h never accepted", w);
        end
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        bit acc, saw_act;
        int n;
        int r;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("rst_status", status, 32'h2);
        chk("rst_stall", stall, 0);
        chk("rst_start", start, 0);
        chk("rst_data", spi_data, 0);
        // busy held high: nothing launches, so cnt follows pushes and flushes only
        tbl[0]  = '{1'b0, TX,            32'h11, 1'b0, 0};
        tbl[1]  = '{1'b1, 32'h100,       32'h12, 1'b0, 0};
        tbl[2]  = '{1'b1, TX,            32'h13, 1'b0, 1};
        tbl[3]  = '{1'b1, TX,            32'h14, 1'b0, 2};
        tbl[4]  = '{1'b1, TX,            32'h15, 1'b0, 3};
        tbl[5]  = '{1'b1, TX,            32'h16, 1'b0, 4};
        tbl[6]  = '{1'b1, TX,            32'h17, 1'b1, 4};
        tbl[7]  = '{1'b1, CTRL,          32'h2,  1'b0, 4};
        tbl[8]  = '{1'b0, TX,            32'h18, 1'b0, 4};
        tbl[9]  = '{1'b1, CTRL,          32'h0,  1'b0, 4};
        tbl[10] = '{1'b1, CTRL,          32'h1,  1'b0, 0};
        tbl[11] = '{1'b1, TX,            32'h19, 1'b0, 1};
        tbl[12] = '{1'b1, 32'h0000_00F4, 32'h1A, 1'b0, 1};
        tbl[13] = '{1'b1, CTRL,          32'h3,  1'b0, 0};
        busy = 1;
        for (int i = 0; i < 14; i++) begin
            we = tbl[i].we;
            addr = tbl[i].addr;
            data = tbl[i].data;
            #1;
            chk($sformatf("tbl%0d_stall", i), stall, 32'(tbl[i].exp_stall));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_cnt", i), status[7:4], 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_idle", i), status[0], 0);
        end
        // single word, busy 10 cycles
        do_reset();
        bm_en = 1;
        busy_dly = 1;
        busy_len = 10;
        push_word(32'hA5A5_0001);
        step();
        chk("t2_start", start, 1);
        chk("t2_data", spi_data, 32'hA5A5_0001);
        saw_act = status[0];
        repeat (25) step();
        chk("t2_saw_active", saw_act, 1);
        chk("t2_starts", starts, 1);
        chk("t2_active_end", status[0], 0);
        chk("t2_empty_end", status[1], 1);
        chk("t2_data_hold", spi_data, 32'hA5A5_0001);
        // five stores with busy held: the fifth stalls until one cycle after the first pop
        do_reset();
        bm_en = 0;
        busy = 1;
        for (int i = 0; i < 4; i++) push_word(32'hB000_0000 + i);
        we = 1;
        addr = TX;
        data = 32'hB000_0004;
        step();
        #1;
        chk("t3_stall", stall, 1);
        step();
        busy = 0;
        bm_en = 1;
        busy_dly = 1;
        busy_len = 4;
        n = 0;
        acc = 0;
        while (!acc && n < 10) begin
            acc = q.size() < DEPTH;
            step();
            n++;
        end
        we = 0;
        chk("t3_release", n, 2);
        repeat (80) step();
        chk("t3_starts", starts, 5);
        chk("t3_cnt_end", status[7:4], 0);
        // busy never rises: sticky error, word dropped, next word still launches
        do_reset();
        bm_en = 1;
        busy_dly = 1000;
        push_word(32'hC0DE_0001);
        n = 0;
        while (starts == 0 && n < 5) begin
            step();
            n++;
        end
        chk("t4_first_start", starts, 1);
        busy_dly = 1;
        push_word(32'hC0DE_0002);
        n = 0;
        while (!status[3] && n < 30) begin
            step();
            n++;
        end
        chk("t4_tmo_cycles", n, 16);
        chk("t4_err", status[3], 1);
        chk("t4_idle", status[0], 0);
        n = 0;
        while (starts < 2 && n < 5) begin
            step();
            n++;
        end
        chk("t4_second_start", starts, 2);
        chk("t4_sticky", status[3], 1);
        we = 1;
        addr = CTRL;
        data = 32'h2;
        step();
        we = 0;
        chk("t4_err_clr", status[3], 0);
        repeat (20) step();
        chk("t4_done", status[0], 0);
        // flush with three queued while a transfer is in flight
        do_reset();
        bm_en = 1;
        busy_dly = 1;
        busy_len = 8;
        for (int i = 0; i < 4; i++) push_word(32'hD0D0_0000 + i);
        repeat (2) step();
        chk("t5_pre_cnt", status[7:4], 3);
        we = 1;
        addr = CTRL;
        data = 32'h1;
        step();
        we = 0;
        chk("t5_cnt", status[7:4], 0);
        chk("t5_empty", status[1], 1);
        chk("t5_inflight", status[0], 1);
        repeat (20) step();
        chk("t5_starts", starts, 1);
        chk("t5_complete", status[0], 0);
        push_word(32'hD0D0_0009);
        repeat (15) step();
        chk("t5_after", starts, 2);
        chk("t5_after_data", spi_data, 32'hD0D0_0009);
        // push and pop on the same edge at cnt=2, then wraparound over ten words
        do_reset();
        bm_en = 0;
        busy = 1;
        push_word(32'hE000_0000);
        push_word(32'hE000_0001);
        busy = 0;
        bm_en = 1;
        busy_dly = 1;
        busy_len = 2;
        we = 1;
        addr = TX;
        data = 32'hE000_0002;
        step();
        we = 0;
        chk("t6_start", start, 1);
        chk("t6_cnt", status[7:4], 2);
        for (int i = 3; i < 10; i++) push_word(32'hE000_0000 + i);
        repeat (60) step();
        chk("t6_starts", starts, 10);
        chk("t6_cnt_end", status[7:4], 0);
        // random traffic against the queue model
        do_reset();
        bm_en = 1;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            data = $urandom;
            we = 1;
            if (r < 45) addr = TX;
            else if (r < 52) begin
                addr = CTRL;
                data[0] = $urandom_range(0, 7) == 0;
            end else if (r < 62) addr = $urandom & 32'hFFFF_FF00;
            else begin
                we = 0;
                addr = ($urandom_range(0, 1) == 1) ? TX : CTRL;
            end
            busy_dly = $urandom_range(1, 3);
            busy_len = $urandom_range(1, 5);
            step();
        end
        we = 0;
        repeat (60) step();
        chk("rand_drained", status[7:4], 0);
        chk("rand_idle", status[0], 0);
        chk("rand_no_err", status[3], 0);
        // reset mid-WAIT_LO with three words queued
        do_reset();
        bm_en = 1;
        busy_dly = 1;
        busy_len = 20;
        for (int i = 0; i < 4; i++) push_word(32'hF000_0000 + i);
        repeat (3) step();
        chk("t1_pre_cnt", status[7:4], 3);
        chk("t1_pre_active", status[0], 1);
        do_reset();
        chk("t1_status", status, 32'h2);
        chk("t1_start", start, 0);
        chk("t1_data", spi_data, 0);
        chk("t1_stall", stall, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
